branch_ctrl: RTL and testbench

- Control-flow stage directly upstream of the program counter in the single-cycle accumulator processor.
- Each cycle it takes the current pc_count, the decoded opcode/target of the executing instruction and the accumulator result, and drives jump_enable/jump_value into the pc.
- Holds the registered condition flags (zero, negative), a small return-address stack for CALL/RET, and a RUN/HALT state machine.

---
 rtl/branch_ctrl_pkg.sv | 29 ++
 rtl/branch_ctrl_ras_stack.sv | 69 ++++++
 rtl/branch_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_branch_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_ctrl_pkg
// Shared definitions for the control-flow stage of the accumulator processor:
// default widths, the control-flow opcode field values (also used by the
// instruction decoder) and the RUN/HALT state encoding.
// -----------------------------------------------------------------------------
package branch_ctrl_pkg;

    localparam int PC_W      = 6;
    localparam int ACC_W     = 8;
    localparam int RAS_DEPTH = 4;
    localparam int SP_W      = 3;

    // Control-flow opcode field; any value not listed here is a NOP.
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_JMP  = 4'd1;
    localparam logic [3:0] OP_JZ   = 4'd2;
    localparam logic [3:0] OP_JNZ  = 4'd3;
    localparam logic [3:0] OP_JN   = 4'd4;
    localparam logic [3:0] OP_CALL = 4'd5;
    localparam logic [3:0] OP_RET  = 4'd6;
    localparam logic [3:0] OP_HLT  = 4'd7;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/branch_ctrl_ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Return-address LIFO. A push writes i_data above the current top, a pop
// discards the top entry. Pushes when full and pops when empty are ignored;
// the owner decides what an overflow/underflow means.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset (clears depth)
//   i_push, i_pop    push i_data / pop top (mutually exclusive by the owner)
//   i_data           value to push
//   o_top            current top entry (undefined when empty)
//   o_depth          number of valid entries
//   o_full, o_empty  depth == DEPTH / depth == 0
// -----------------------------------------------------------------------------
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int DW    = 6,
    parameter int SP_W  = 3
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [DW-1:0]   i_data,
    output logic [DW-1:0]   o_top,
    output logic [SP_W-1:0] o_depth,
    output logic            o_full,
    output logic            o_empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]    r_mem [DEPTH];
    logic [SP_W-1:0]  r_depth;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_top_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_depth == SP_W'(DEPTH));
    assign o_empty   = (r_depth == {SP_W{1'b0}});
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    // Entry k lives at slot k; the top is slot depth-1 (wraps harmlessly when empty).
    assign w_wr_idx  = IDX_W'(r_depth);
    assign w_top_idx = IDX_W'(r_depth - SP_W'(1));
    assign o_top     = r_mem[w_top_idx];
    assign o_depth   = r_depth;

    // Depth counter: the only state that reset must clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_depth <= {SP_W{1'b0}};
        end else if (w_do_push) begin
            r_depth <= r_depth + SP_W'(1);
        end else if (w_do_pop) begin
            r_depth <= r_depth - SP_W'(1);
        end else begin
            r_depth <= r_depth;
        end
    end

    // Entry storage: contents are don't-care after reset, so no reset here.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_reset) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
// Control-flow stage feeding the program counter. Each cycle it decodes the
// control-flow opcode of the executing instruction and drives a zero-cycle
// jump request (o_jump_enable/o_jump_value) that the pc applies at the next
// edge. Holds the registered zero/negative flags, a return-address stack for
// CALL/RET and a RUN/HALT state machine. HALT is left only through reset.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_pc_count            address of the instruction executing this cycle
//   i_opcode, i_target    control-flow field and branch/call target
//   i_acc_value, i_acc_we accumulator write this cycle (updates the flags)
//   o_jump_enable         pc loads o_jump_value at the next edge
//   o_jump_value          next pc when o_jump_enable=1
//   o_halted              state is HALT
//   o_stack_err           sticky CALL overflow / RET underflow
//   o_ras_depth           number of valid return-stack entries
// -----------------------------------------------------------------------------
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int PC_W      = branch_ctrl_pkg::PC_W,
    parameter int ACC_W     = branch_ctrl_pkg::ACC_W,
    parameter int RAS_DEPTH = branch_ctrl_pkg::RAS_DEPTH,
    parameter int SP_W      = branch_ctrl_pkg::SP_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [PC_W-1:0]  i_pc_count,
    input  logic [3:0]       i_opcode,
    input  logic [PC_W-1:0]  i_target,
    input  logic [ACC_W-1:0] i_acc_value,
    input  logic             i_acc_we,
    output logic             o_jump_enable,
    output logic [PC_W-1:0]  o_jump_value,
    output logic             o_halted,
    output logic             o_stack_err,
    output logic [SP_W-1:0]  o_ras_depth
);

    state_t          r_state;
    state_t          w_next_state;
    logic            r_flag_z;
    logic            r_flag_n;
    logic            r_stack_err;

    logic            w_jump_enable;
    logic [PC_W-1:0] w_jump_value;
    logic            w_push;
    logic            w_pop;
    logic            w_set_err;
    logic [PC_W-1:0] w_ret_addr;
    logic [PC_W-1:0] w_top;
    logic            w_full;
    logic            w_empty;

    // Return address wraps naturally at 2^PC_W.
    assign w_ret_addr = i_pc_count + PC_W'(1);

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .DW    (PC_W),
        .SP_W  (SP_W)
    ) u_ras (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_ret_addr),
        .o_top   (w_top),
        .o_depth (o_ras_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-state, jump request and stack control decode.
    always_comb begin
        w_next_state  = r_state;
        w_jump_enable = 1'b0;
        w_jump_value  = {PC_W{1'b0}};
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_set_err     = 1'b0;
        if (i_reset) begin
            w_next_state = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    case (i_opcode)
                        OP_JMP: begin
                            w_jump_enable = 1'b1;
                            w_jump_value  = i_target;
                        end
                        // Conditional branches see only flags registered on earlier edges.
                        OP_JZ: begin
                            w_jump_enable = r_flag_z;
                            w_jump_value  = i_target;
                        end
                        OP_JNZ: begin
                            w_jump_enable = !r_flag_z;
                            w_jump_value  = i_target;
                        end
                        OP_JN: begin
                            w_jump_enable = r_flag_n;
                            w_jump_value  = i_target;
                        end
                        OP_CALL: begin
                            if (!w_full) begin
                                w_push        = 1'b1;
                                w_jump_enable = 1'b1;
                                w_jump_value  = i_target;
                            end else begin
                                // Overflow: hold the pc here and stop.
                                w_jump_enable = 1'b1;
                                w_jump_value  = i_pc_count;
                                w_next_state  = ST_HALT;
                                w_set_err     = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (!w_empty) begin
                                w_pop         = 1'b1;
                                w_jump_enable = 1'b1;
                                w_jump_value  = w_top;
                            end else begin
                                // Underflow: hold the pc here and stop.
                                w_jump_enable = 1'b1;
                                w_jump_value  = i_pc_count;
                                w_next_state  = ST_HALT;
                                w_set_err     = 1'b1;
                            end
                        end
                        OP_HLT: begin
                            w_jump_enable = 1'b1;
                            w_jump_value  = i_pc_count;
                            w_next_state  = ST_HALT;
                        end
                        default: begin
                            w_jump_enable = 1'b0;
                            w_jump_value  = {PC_W{1'b0}};
                        end
                    endcase
                end
                ST_HALT: begin
                    // Pc frozen, opcode ignored, stack untouched.
                    w_jump_enable = 1'b1;
                    w_jump_value  = i_pc_count;
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    // State, condition flags and sticky stack error.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_flag_z    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_stack_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Flags keep tracking the accumulator even while halted.
            if (i_acc_we) begin
                r_flag_z <= (i_acc_value == {ACC_W{1'b0}});
                r_flag_n <= i_acc_value[ACC_W-1];
            end else begin
                r_flag_z <= r_flag_z;
                r_flag_n <= r_flag_n;
            end
            if (w_set_err) begin
                r_stack_err <= 1'b1;
            end else begin
                r_stack_err <= r_stack_err;
            end
        end
    end

    assign o_jump_enable = w_jump_enable;
    assign o_jump_value  = w_jump_value;
    assign o_halted      = (r_state == ST_HALT);
    assign o_stack_err   = r_stack_err;

endmodule

// File: tb/tb_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_ctrl
// Directed vector table with hand-derived expectations, followed by random
// stimulus compared against a queue-based reference model of the
// control-flow rules.
// -----------------------------------------------------------------------------
module tb_branch_ctrl;
    import branch_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             i_reset;
    logic [PC_W-1:0]  i_pc_count;
    logic [3:0]       i_opcode;
    logic [PC_W-1:0]  i_target;
    logic [ACC_W-1:0] i_acc_value;
    logic             i_acc_we;
    logic             o_jump_enable;
    logic [PC_W-1:0]  o_jump_value;
    logic             o_halted;
    logic             o_stack_err;
    logic [SP_W-1:0]  o_ras_depth;

    branch_ctrl dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_pc_count    (i_pc_count),
        .i_opcode      (i_opcode),
        .i_target      (i_target),
        .i_acc_value   (i_acc_value),
        .i_acc_we      (i_acc_we),
        .o_jump_enable (o_jump_enable),
        .o_jump_value  (o_jump_value),
        .o_halted      (o_halted),
        .o_stack_err   (o_stack_err),
        .o_ras_depth   (o_ras_depth)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         rst;
        logic [3:0] op;
        int         tgt;
        int         pc;
        int         acc;
        bit         we;
        int         je;
        int         jv;
        int         halt;
        int         err;
        int         depth;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    bit m_halt, m_err, m_z, m_n;
    int m_ras[$];

    function automatic void v(bit rst, logic [3:0] op, int tgt, int pc, int acc, bit we,
                              int je, int jv, int halt, int err, int depth);
        vec_t t;
        t.rst = rst; t.op = op; t.tgt = tgt; t.pc = pc; t.acc = acc; t.we = we;
        t.je = je; t.jv = jv; t.halt = halt; t.err = err; t.depth = depth;
        vecs.push_back(t);
    endfunction

    task automatic drive(bit rst, logic [3:0] op, int tgt, int pc, int acc, bit we);
        i_reset     = rst;
        i_opcode    = op;
        i_target    = PC_W'(tgt);
        i_pc_count  = PC_W'(pc);
        i_acc_value = ACC_W'(acc);
        i_acc_we    = we;
    endtask

    task automatic check(string name, int idx, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(string tag, int idx, int je, int jv, int halt, int err, int depth);
        check({tag, ".jump_enable"}, idx, int'(o_jump_enable), je);
        check({tag, ".jump_value"},  idx, int'(o_jump_value),  jv);
        check({tag, ".halted"},      idx, int'(o_halted),      halt);
        check({tag, ".stack_err"},   idx, int'(o_stack_err),   err);
        check({tag, ".ras_depth"},   idx, int'(o_ras_depth),   depth);
    endtask

    // Spec-level model: expected jump request from pre-edge state, then advance.
    task automatic model_step(bit rst, logic [3:0] op, int tgt, int pc, int acc, bit we,
                              output int eje, output int ejv);
        eje = 0;
        ejv = 0;
        if (rst) begin
            m_halt = 1'b0; m_err = 1'b0; m_z = 1'b0; m_n = 1'b0;
            m_ras.delete();
        end else begin
            if (m_halt) begin
                eje = 1; ejv = pc;
            end else begin
                case (op)
                    OP_JMP:  begin eje = 1; ejv = tgt; end
                    OP_JZ:   begin eje = m_z ? 1 : 0; ejv = tgt; end
                    OP_JNZ:  begin eje = m_z ? 0 : 1; ejv = tgt; end
                    OP_JN:   begin eje = m_n ? 1 : 0; ejv = tgt; end
                    OP_CALL: begin
                        if (m_ras.size() < RAS_DEPTH) begin
                            m_ras.push_back((pc + 1) % 64);
                            eje = 1; ejv = tgt;
                        end else begin
                            eje = 1; ejv = pc; m_halt = 1'b1; m_err = 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (m_ras.size() > 0) begin
                            eje = 1; ejv = m_ras.pop_back();
                        end else begin
                            eje = 1; ejv = pc; m_halt = 1'b1; m_err = 1'b1;
                        end
                    end
                    OP_HLT:  begin eje = 1; ejv = pc; m_halt = 1'b1; end
                    default: begin eje = 0; ejv = 0; end
                endcase
            end
            if (we) begin
                m_z = (acc == 0);
                m_n = (acc >= 128);
            end
        end
    endtask

    initial begin
        int eje, ejv, eh, ee, ed;
        bit rst, we;
        logic [3:0] op;
        int tgt, pc, acc;

        drive(1'b1, OP_NOP, 0, 0, 0, 1'b0);
        @(posedge clk); #1;

        //  rst op       tgt pc  acc  we   je jv  h  e  d
        v(1, OP_JMP,  30, 0,  0,   0,   0, 0,  0, 0, 0);
        v(0, OP_JMP,  30, 0,  0,   0,   1, 30, 0, 0, 0);
        v(0, OP_NOP,  0,  1,  0,   1,   0, 0,  0, 0, 0);
        v(0, OP_JZ,   12, 2,  5,   1,   1, 12, 0, 0, 0);  // same-cycle write ignored
        v(0, OP_JZ,   12, 3,  0,   0,   0, 12, 0, 0, 0);
        v(0, OP_JNZ,  40, 4,  0,   0,   1, 40, 0, 0, 0);
        v(0, OP_NOP,  0,  5,  128, 1,   0, 0,  0, 0, 0);
        v(0, OP_JN,   7,  6,  0,   0,   1, 7,  0, 0, 0);
        v(0, OP_JNZ,  9,  7,  0,   1,   1, 9,  0, 0, 0);
        v(0, OP_JN,   7,  8,  0,   0,   0, 7,  0, 0, 0);
        v(0, OP_JNZ,  9,  9,  0,   0,   0, 9,  0, 0, 0);
        v(0, OP_CALL, 20, 5,  0,   0,   1, 20, 0, 0, 0);
        v(0, OP_RET,  0,  22, 0,   0,   1, 6,  0, 0, 1);
        v(0, OP_CALL, 10, 63, 0,   0,   1, 10, 0, 0, 0);
        v(0, OP_RET,  0,  11, 0,   0,   1, 0,  0, 0, 1);  // wrapped return address
        v(0, 4'hF,    33, 3,  0,   0,   0, 0,  0, 0, 0);
        for (int k = 0; k < 4; k++)
            v(0, OP_CALL, k + 1, k + 10, 0, 0, 1, k + 1, 0, 0, k);
        v(0, OP_CALL, 5,  14, 0,   0,   1, 14, 0, 0, 4);  // overflow
        v(0, OP_JMP,  3,  14, 0,   0,   1, 14, 1, 1, 4);
        v(0, OP_RET,  0,  14, 0,   0,   1, 14, 1, 1, 4);
        v(1, OP_JMP,  3,  14, 0,   0,   0, 0,  1, 1, 4);
        v(0, OP_RET,  0,  0,  0,   0,   1, 0,  0, 0, 0);  // underflow
        v(0, OP_JMP,  5,  0,  0,   0,   1, 0,  1, 1, 0);
        v(1, OP_NOP,  0,  0,  0,   0,   0, 0,  1, 1, 0);
        v(0, OP_CALL, 30, 1,  0,   0,   1, 30, 0, 0, 0);
        v(0, OP_CALL, 40, 31, 0,   0,   1, 40, 0, 0, 1);
        v(0, OP_HLT,  0,  9,  0,   0,   1, 9,  0, 0, 2);
        v(0, OP_JMP,  3,  9,  0,   0,   1, 9,  1, 0, 2);
        v(0, OP_NOP,  0,  9,  0,   1,   1, 9,  1, 0, 2);  // flags still update in HALT
        v(1, OP_NOP,  0,  9,  0,   0,   0, 0,  1, 0, 2);
        v(0, OP_JZ,   17, 0,  0,   0,   0, 17, 0, 0, 0);  // flag_z cleared by reset
        v(0, OP_RET,  0,  1,  0,   0,   1, 1,  0, 0, 0);  // stack cleared by reset
        v(1, OP_NOP,  0,  0,  0,   0,   0, 0,  1, 1, 0);
        v(0, OP_NOP,  0,  0,  0,   0,   0, 0,  0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].tgt, vecs[i].pc, vecs[i].acc, vecs[i].we);
            @(negedge clk);
            check_outputs("vec", i, vecs[i].je, vecs[i].jv, vecs[i].halt, vecs[i].err, vecs[i].depth);
            @(posedge clk); #1;
        end

        // Random phase against the reference model, starting from reset.
        m_halt = 1'b0; m_err = 1'b0; m_z = 1'b0; m_n = 1'b0;
        m_ras.delete();
        for (int i = 0; i < 800; i++) begin
            rst = (i == 0) || ($urandom_range(11, 0) == 0);
            if ($urandom_range(3, 0) == 0) op = 4'($urandom_range(15, 0));
            else                           op = 4'($urandom_range(6, 1));
            if ($urandom_range(40, 0) == 0) op = OP_HLT;
            tgt = int'($urandom_range(63, 0));
            pc  = int'($urandom_range(63, 0));
            case ($urandom_range(3, 0))
                0:       acc = 0;
                1:       acc = 128 + int'($urandom_range(127, 0));
                default: acc = int'($urandom_range(255, 0));
            endcase
            we = $urandom_range(1, 0) == 1;
            eh = m_halt ? 1 : 0;
            ee = m_err ? 1 : 0;
            ed = m_ras.size();
            drive(rst, op, tgt, pc, acc, we);
            model_step(rst, op, tgt, pc, acc, we, eje, ejv);
            @(negedge clk);
            check_outputs("rnd", i, eje, ejv, eh, ee, ed);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
